// File: rtl/mips_trace_pkg.sv
// rtl/mips_trace_pkg.sv - shared widths, record layout and FSM states for the writeback trace capture
package mips_trace_pkg;

    localparam int PC_W        = 10;
    localparam int DEST_W      = 5;
    localparam int DATA_W      = 32;
    localparam int BODY_W      = PC_W + DEST_W + DATA_W;
    localparam int TRACE_CYC_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } trace_state_e;

    typedef struct packed {
        logic [TRACE_CYC_W-1:0] ts;
        logic [PC_W-1:0]        pc;
        logic [DEST_W-1:0]      dest;
        logic [DATA_W-1:0]      data;
    } trace_rec_t;

    // Record body below the timestamp: {pc, dest, data}
    function automatic logic [BODY_W-1:0] pack_body(
        input logic [PC_W-1:0]   pc,
        input logic [DEST_W-1:0] dest,
        input logic [DATA_W-1:0] data
    );
        return {pc, dest, data};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous FIFO with extra-MSB pointers, flush, full flag and occupancy count
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 63
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         empty;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count   = wptr - rptr;
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Gate the head so nothing stale is visible while empty
    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/mips_wb_trace.sv
// rtl/mips_wb_trace.sv - MIPS writeback trace capture into a drained FIFO; TRACE_TIMESTAMP_EN adds cycle stamps
module mips_wb_trace
    import mips_trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CYC_W = 16,
    parameter int OVF_W = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      RegWrite_wb_in,
    input  logic [DEST_W-1:0]         dest_wb_in,
    input  logic [DATA_W-1:0]         write_data_in,
    input  logic [PC_W-1:0]           PC_in,
    input  logic                      trace_start,
    input  logic                      trace_stop,
    input  logic                      trace_clear,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BODY_W+CYC_W-1:0]   out_data,
    output logic                      overflow,
    output logic [OVF_W-1:0]          drop_cnt,
    output logic [1:0]                state_out
);

    localparam int AW = $clog2(DEPTH);

    trace_state_e     state_q;
    trace_state_e     state_d;
    logic [CYC_W-1:0] ts;
    logic             fifo_full;
    logic [AW:0]      fifo_count;
    logic             cap_event;
    logic             pop;
    logic             drop;

`ifdef TRACE_TIMESTAMP_EN
    logic [CYC_W-1:0] ts_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q <= '0;
        end else if (trace_clear) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + CYC_W'(1);
        end
    end

    assign ts = ts_q;
`else
    assign ts = '0;
`endif

    // Writes to $0 are architectural no-ops and are never traced
    assign cap_event = (state_q == RUN) && RegWrite_wb_in && (dest_wb_in != '0) && !trace_clear;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign drop      = cap_event && fifo_full && !pop;

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (BODY_W + CYC_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cap_event),
        .pop   (pop),
        .flush (trace_clear),
        .wdata ({ts, pack_body(PC_in, dest_wb_in, write_data_in)}),
        .rdata (out_data),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (trace_clear) begin
            state_d = IDLE;
        end else if (trace_stop && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (trace_start) state_d = RUN;
                RUN:     if (drop)        state_d = HALT;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (trace_clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + OVF_W'(1);
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_mips_wb_trace.sv
// tb/tb_mips_wb_trace.sv - scoreboard bench for mips_wb_trace with a queue-based reference model
module tb_mips_wb_trace;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        RegWrite_wb_in;
    logic [4:0]  dest_wb_in;
    logic [31:0] write_data_in;
    logic [9:0]  PC_in;
    logic        trace_start;
    logic        trace_stop;
    logic        trace_clear;
    logic        out_valid;
    logic        out_ready;
    logic [62:0] out_data;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic [1:0]  state_out;

    int checks   = 0;
    int failures = 0;

    logic [62:0] exp_q[$];
    int          m_cnt;
    logic        m_ovf;
    logic [7:0]  m_drop;
    logic [15:0] m_cyc;
    int          m_st;

    mips_wb_trace #(.DEPTH(DEPTH), .CYC_W(16), .OVF_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .RegWrite_wb_in (RegWrite_wb_in),
        .dest_wb_in     (dest_wb_in),
        .write_data_in  (write_data_in),
        .PC_in          (PC_in),
        .trace_start    (trace_start),
        .trace_stop     (trace_stop),
        .trace_clear    (trace_clear),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .state_out      (state_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: capacity-limited queue, counters and mode updated on each clock edge
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_cnt = 0; m_ovf = 0; m_drop = 0; m_cyc = 0; m_st = 0;
            exp_q.delete();
        end else if (trace_clear) begin
            m_cnt = 0; m_ovf = 0; m_drop = 0; m_cyc = 0; m_st = 0;
            exp_q.delete();
        end else begin
            bit          pop;
            bit          cap;
            bit          dropped;
            logic [15:0] ts;
            pop = (m_cnt > 0) && out_ready;
            cap = (m_st == 1) && RegWrite_wb_in && (dest_wb_in != 0);
            dropped = 0;
`ifdef TRACE_TIMESTAMP_EN
            ts = m_cyc;
`else
            ts = 16'd0;
`endif
            if (pop) m_cnt--;
            if (cap) begin
                if (m_cnt < DEPTH) begin
                    m_cnt++;
                    exp_q.push_back({ts, PC_in, dest_wb_in, write_data_in});
                end else begin
                    dropped = 1;
                    m_ovf = 1;
                    if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                end
            end
            if (trace_stop && m_st != 0) m_st = 0;
            else if (m_st == 0 && trace_start) m_st = 1;
            else if (m_st == 1 && dropped) m_st = 2;
            m_cyc = m_cyc + 16'd1;
        end
    end

    // Monitor: compares the presented record to the scoreboard head; pops on handshake
    always @(negedge clock) begin
        if (reset) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, (m_cnt > 0)});
            if (out_valid && exp_q.size() > 0) begin
                chk("out_data", {1'b0, out_data}, {1'b0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
            chk("state", {62'd0, state_out}, 64'(m_st));
            chk("overflow", {63'd0, overflow}, {63'd0, m_ovf});
            chk("drop_cnt", {56'd0, drop_cnt}, {56'd0, m_drop});
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        trace_start = 1; cyc(); trace_start = 0;
    endtask

    task automatic pulse_stop();
        trace_stop = 1; cyc(); trace_stop = 0;
    endtask

    task automatic pulse_clear();
        trace_clear = 1; cyc(); trace_clear = 0;
    endtask

    task automatic ev(input logic [4:0] d, input logic [31:0] v, input logic [9:0] pc);
        RegWrite_wb_in = 1; dest_wb_in = d; write_data_in = v; PC_in = pc;
        cyc();
        RegWrite_wb_in = 0;
    endtask

    initial begin
        reset = 0; RegWrite_wb_in = 0; dest_wb_in = 0; write_data_in = 0; PC_in = 0;
        trace_start = 0; trace_stop = 0; trace_clear = 0; out_ready = 0;
        #2;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_data", {1'b0, out_data}, 64'd0);
        chk("rst_state", {62'd0, state_out}, 64'd0);
        repeat (3) @(posedge clock);
        #1 reset = 1;

        // Single event and its one-cycle latency
        pulse_start();
        out_ready = 1;
        ev(5'd5, 32'hDEADBEEF, 10'h010);
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_body", {17'd0, out_data[46:0]}, {17'd0, 10'h010, 5'd5, 32'hDEADBEEF});

        // Write to $0 is ignored
        ev(5'd0, 32'h12345678, 10'h011);
        chk("t2_valid", {63'd0, out_valid}, 64'd0);

        // Overflow with 18 events into a stalled 16-deep FIFO
        pulse_clear();
        pulse_start();
        out_ready = 0;
        for (int i = 0; i < 18; i++) ev(5'(i % 31 + 1), $urandom, 10'(i));
        chk("t3_ovf", {63'd0, overflow}, 64'd1);
        chk("t3_drop", {56'd0, drop_cnt}, 64'd1);
        chk("t3_state", {62'd0, state_out}, 64'd2);

        // Full FIFO, push and pop on the same edge
        pulse_stop();
        pulse_start();
        out_ready = 1;
        ev(5'd7, 32'hCAFEF00D, 10'h3FF);
        out_ready = 0;
        chk("t4_drop", {56'd0, drop_cnt}, 64'd1);
        chk("t4_state", {62'd0, state_out}, 64'd1);
        out_ready = 1;
        repeat (20) cyc();

        // Toggling ready over 8 records
        for (int i = 0; i < 8; i++) begin
            out_ready = (i % 2 == 0);
            ev(5'(i + 3), $urandom, 10'(i + 100));
        end
        for (int i = 0; i < 20; i++) begin
            out_ready = (i % 2 == 0);
            cyc();
        end

        // Async reset mid-drain
        out_ready = 0;
        for (int i = 0; i < 5; i++) ev(5'(i + 1), $urandom, 10'(i + 200));
        out_ready = 1;
        cyc();
        #1 reset = 0;
        #1;
        chk("t6_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_drop", {56'd0, drop_cnt}, 64'd0);
        chk("t6_data", {1'b0, out_data}, 64'd0);
        chk("t6_ovf", {63'd0, overflow}, 64'd0);
        chk("t6_state", {62'd0, state_out}, 64'd0);
        @(posedge clock);
        #1 reset = 1;
        repeat (3) cyc();
        pulse_start();
        repeat (2) cyc();
        ev(5'd9, 32'h0BADF00D, 10'h123);
        repeat (3) cyc();

        // Drop counter saturation
        pulse_clear();
        pulse_start();
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) ev(5'd1, $urandom, 10'(i));
        for (int i = 0; i < 258; i++) begin
            ev(5'd2, $urandom, 10'h2AA);
            pulse_stop();
            pulse_start();
        end
        chk("sat_drop", {56'd0, drop_cnt}, 64'hFF);
        pulse_clear();
        chk("clr_drop", {56'd0, drop_cnt}, 64'd0);
        chk("clr_valid", {63'd0, out_valid}, 64'd0);

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            RegWrite_wb_in = ($urandom_range(0, 99) < 60);
            dest_wb_in     = 5'($urandom_range(0, 31));
            write_data_in  = $urandom;
            PC_in          = 10'($urandom);
            out_ready      = ($urandom_range(0, 99) < 55);
            trace_start    = ($urandom_range(0, 99) < 6);
            trace_stop     = ($urandom_range(0, 99) < 3);
            trace_clear    = ($urandom_range(0, 199) < 1);
            cyc();
        end
        RegWrite_wb_in = 0; trace_start = 0; trace_stop = 0; trace_clear = 0;
        out_ready = 1;
        repeat (DEPTH + 4) cyc();
        chk("end_valid", {63'd0, out_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
